mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multicycle control unit for the MIPS-subset datapath. It is the initiator of every register-file write.
- It sequences IF/DCD/EXE/MEM/WB from the latched IR opcode/funct and drives gprwr, RegDst, MemToReg and write_30 into gpr, plus PC, IR, ALU and data-memory controls.
- Moore FSM: outputs decode from the state register and the op/funct inputs. IR is stable from DCD through WB.

Parameters:
- STATE_W, 3, width of state register (must hold 6 states incl. optional TRAP).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets on next rising clk edge)
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (valid in EXE)
- pcwr  out  1  PC write enable
- npc_op  out  2  next-PC select: 00 pc+4, 01 branch target, 10 jump target
- irwr  out  1  IR write enable
- gprwr  out  1  gpr write enable
- RegDst  out  2  gpr write address: 00 rt, 01 rd, 10 $31
- MemToReg  out  2  gpr write data: 00 aluReg_out, 01 dmReg_out, 10 pc_p4
- write_30  out  1  addi writeback; gpr routes overflow flag to $30
- ExtOp  out  1  immediate extension: 0 zero, 1 sign
- AluSrc  out  1  ALU B operand: 0 register B, 1 extended immediate
- AluOp  out  3  000 add, 001 sub, 010 or, 011 slt, 100 lui (imm<<16)
- dmwr  out  1  data-memory write enable

Behaviour:
- States: IF, DCD, EXE, MEM, WB (TRAP only with the optional feature).
- Reset: while rst=0 at a clk edge, state<=IF. All outputs are forced to 0 combinationally while rst=0; npc_op=00 and AluOp=000 during reset.
- Reset mid-instruction aborts it: no gprwr or dmwr pulse is issued after rst falls, even if the FSM was in WB/MEM.
- First cycle after release is IF.
- IF: pcwr=1, npc_op=00, irwr=1. Next state is DCD.
- Opcodes:
  - R-type 000000: funct 100001 addu, 100011 subu, 101010 slt
  - ori 001101
  - lui 001111
  - addi 001000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - jal 000011
- DCD:
  - j: pcwr=1, npc_op=10. Next state IF (2 cycles total).
  - jal: pcwr=1, npc_op=10, gprwr=1, RegDst=10, MemToReg=10. Next state IF (2 cycles).
  - Illegal op, or R-type with unlisted funct: all enables 0. Next state IF (NOP, 2 cycles).
  - All others: next state EXE.
- EXE: AluOp/AluSrc/ExtOp are driven per instruction and held for the whole state.
  - addu: 000/0/x
  - subu: 001/0/x
  - slt: 011/0/x
  - ori: 010/1/0
  - lui: 100/1/0
  - addi: 000/1/1
  - lw/sw: 000/1/1
  - beq: 001/0/1, npc_op=01, pcwr=zero. Next state IF (3 cycles).
  - lw/sw: next state MEM.
  - Others: next state WB.
- MEM:
  - sw: dmwr=1 for exactly one cycle. Next state IF (4 cycles).
  - lw: next state WB.
- WB: gprwr=1 for exactly one cycle. Next state IF.
  - R-type: RegDst=01, MemToReg=00.
  - ori/lui: RegDst=00, MemToReg=00.
  - addi: RegDst=00, MemToReg=00, write_30=1.
  - lw: RegDst=00, MemToReg=01 (5 cycles).
- Cycle counts: R/ori/lui/addi 4, lw 5, sw 4, beq 3, j/jal 2.
- Signals not listed for a state are 0; x means don't-care and is driven 0.
- gprwr, dmwr, pcwr and irwr are never asserted in the same cycle except pcwr+irwr (IF) and pcwr+gprwr (jal DCD).
- Unused state encodings return to IF on the next edge.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal op/funct in DCD transitions to TRAP.
  - TRAP: all enables 0; it holds until rst=0.
  - Extra output port illegal (1 bit) is 1 only in TRAP.
- Undefined: illegal instructions execute as 2-cycle NOP as above; no TRAP state and no illegal port.

Test Plan:
- Reset/release: rst=0 for 2 edges while state=WB of addu → gprwr=0 throughout. After rst=1, cycle 1 shows pcwr=1, irwr=1, npc_op=00.
- addu (op=0, funct=100001) → 4-cycle sequence. WB cycle: gprwr=1, RegDst=01, MemToReg=00, write_30=0. Then IF.
- lw (op=100011) then sw (op=101011):
  - lw is 5 cycles, with WB gprwr=1, RegDst=00, MemToReg=01.
  - sw is 4 cycles, with dmwr=1 only in MEM and gprwr never 1.
- beq (op=000100):
  - zero=1 → EXE pcwr=1, npc_op=01.
  - zero=0 → EXE pcwr=0.
  - Both cases: 3 cycles, no gprwr.
- jal (op=000011) → DCD cycle: pcwr=1, npc_op=10, gprwr=1, RegDst=10, MemToReg=10. Next cycle IF. j (op=000010) is the same without gprwr.
- addi (op=001000) → EXE AluOp=000, AluSrc=1, ExtOp=1. WB write_30=1, gprwr=1.
- op=111111:
  - Without macro: returns to IF after 2 cycles with no enables.
  - With macro: enters TRAP, illegal=1 until rst=0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if
// Bundle between the multicycle control unit and the datapath.
//
// Signals
//   op, funct, zero     : datapath -> controller (IR fields, ALU zero flag)
//   pcwr, npc_op        : PC write enable and next-PC select
//   irwr                : IR write enable
//   gprwr, RegDst,
//   MemToReg, write_30  : register-file write controls
//   ExtOp, AluSrc, AluOp: immediate extension and ALU controls
//   dmwr                : data-memory write enable
//   illegal             : present only with MC_CTRL_ILLEGAL_TRAP_EN defined
//
// Handshake semantics: there is no valid/ready pair here. Every control output
// is a level that is meaningful in the cycle it is asserted; write enables
// (pcwr, irwr, gprwr, dmwr) take effect at the next rising clock edge.
//
// Modports
//   master : the controller (drives all controls)
//   slave  : the datapath (drives op/funct/zero)
// -----------------------------------------------------------------------------
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcwr;
    logic [1:0] npc_op;
    logic       irwr;
    logic       gprwr;
    logic [1:0] RegDst;
    logic [1:0] MemToReg;
    logic       write_30;
    logic       ExtOp;
    logic       AluSrc;
    logic [2:0] AluOp;
    logic       dmwr;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    modport master (
        input  op, funct, zero,
        output pcwr, npc_op, irwr, gprwr, RegDst, MemToReg, write_30,
               ExtOp, AluSrc, AluOp, dmwr
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output op, funct, zero,
        input  pcwr, npc_op, irwr, gprwr, RegDst, MemToReg, write_30,
               ExtOp, AluSrc, AluOp, dmwr
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multicycle control unit for the MIPS-subset datapath. Sequences
// IF -> DCD -> EXE -> MEM -> WB from the latched IR op/funct and drives PC, IR,
// ALU, data-memory and register-file controls. Moore-style: outputs decode from
// the state register plus op/funct (IR is stable from DCD through WB).
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous active-low reset
//   bus          : mc_ctrl_if.master (op/funct/zero in, all controls out)
//   o_dbg_state  : current state register, for observation only
//
// Optional feature (macro MC_CTRL_ILLEGAL_TRAP_EN):
//   defined   -> illegal instruction enters TRAP, held until reset,
//                bus.illegal = 1 while in TRAP
//   undefined -> illegal instruction is a 2-cycle NOP
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    mc_ctrl_if.master          bus,
    output logic [STATE_W-1:0] o_dbg_state
);

    typedef enum logic [STATE_W-1:0] {
        S_IF,
        S_DCD,
        S_EXE,
        S_MEM,
        S_WB
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Instruction decode from the IR fields
    logic w_rtype, w_addu, w_subu, w_slt;
    logic w_ori, w_lui, w_addi, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_legal;

    assign w_rtype = (bus.op == 6'b000000);
    assign w_addu  = w_rtype && (bus.funct == 6'b100001);
    assign w_subu  = w_rtype && (bus.funct == 6'b100011);
    assign w_slt   = w_rtype && (bus.funct == 6'b101010);
    assign w_ori   = (bus.op == 6'b001101);
    assign w_lui   = (bus.op == 6'b001111);
    assign w_addi  = (bus.op == 6'b001000);
    assign w_lw    = (bus.op == 6'b100011);
    assign w_sw    = (bus.op == 6'b101011);
    assign w_beq   = (bus.op == 6'b000100);
    assign w_j     = (bus.op == 6'b000010);
    assign w_jal   = (bus.op == 6'b000011);
    assign w_legal = w_addu | w_subu | w_slt | w_ori | w_lui | w_addi |
                     w_lw | w_sw | w_beq | w_j | w_jal;

    logic       w_pcwr;
    logic [1:0] w_npc_op;
    logic       w_irwr;
    logic       w_gprwr;
    logic [1:0] w_reg_dst;
    logic [1:0] w_mem_to_reg;
    logic       w_write_30;
    logic       w_ext_op;
    logic       w_alu_src;
    logic [2:0] w_alu_op;
    logic       w_dmwr;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IF;
        w_pcwr       = 1'b0;
        w_npc_op     = 2'b00;
        w_irwr       = 1'b0;
        w_gprwr      = 1'b0;
        w_reg_dst    = 2'b00;
        w_mem_to_reg = 2'b00;
        w_write_30   = 1'b0;
        w_ext_op     = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = 3'b000;
        w_dmwr       = 1'b0;
        w_illegal    = 1'b0;
        // While rst is low every output stays at its default of 0, which also
        // suppresses any gprwr/dmwr from an instruction caught mid-flight.
        if (rst) begin
            case (r_state)
                S_IF: begin
                    w_pcwr       = 1'b1;
                    w_irwr       = 1'b1;
                    w_next_state = S_DCD;
                end
                S_DCD: begin
                    if (w_j) begin
                        w_pcwr       = 1'b1;
                        w_npc_op     = 2'b10;
                    end else if (w_jal) begin
                        w_pcwr       = 1'b1;
                        w_npc_op     = 2'b10;
                        w_gprwr      = 1'b1;
                        w_reg_dst    = 2'b10;
                        w_mem_to_reg = 2'b10;
                    end else if (!w_legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        w_next_state = S_TRAP;
`else
                        w_next_state = S_IF;
`endif
                    end else begin
                        w_next_state = S_EXE;
                    end
                end
                S_EXE: begin
                    if (w_subu) begin
                        w_alu_op = 3'b001;
                    end else if (w_slt) begin
                        w_alu_op = 3'b011;
                    end else if (w_ori) begin
                        w_alu_op  = 3'b010;
                        w_alu_src = 1'b1;
                    end else if (w_lui) begin
                        w_alu_op  = 3'b100;
                        w_alu_src = 1'b1;
                    end else if (w_addi || w_lw || w_sw) begin
                        w_alu_src = 1'b1;
                        w_ext_op  = 1'b1;
                    end else if (w_beq) begin
                        w_alu_op  = 3'b001;
                        w_ext_op  = 1'b1;
                        w_npc_op  = 2'b01;
                        w_pcwr    = bus.zero;
                    end
                    if (w_beq) begin
                        w_next_state = S_IF;
                    end else if (w_lw || w_sw) begin
                        w_next_state = S_MEM;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
                S_MEM: begin
                    w_dmwr       = w_sw;
                    w_next_state = w_lw ? S_WB : S_IF;
                end
                S_WB: begin
                    w_gprwr      = 1'b1;
                    w_reg_dst    = w_rtype ? 2'b01 : 2'b00;
                    w_mem_to_reg = w_lw ? 2'b01 : 2'b00;
                    w_write_30   = w_addi;
                    w_next_state = S_IF;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    w_illegal    = 1'b1;
                    w_next_state = S_TRAP;
                end
`endif
                default: begin
                    w_next_state = S_IF;
                end
            endcase
        end
    end

    assign bus.pcwr     = w_pcwr;
    assign bus.npc_op   = w_npc_op;
    assign bus.irwr     = w_irwr;
    assign bus.gprwr    = w_gprwr;
    assign bus.RegDst   = w_reg_dst;
    assign bus.MemToReg = w_mem_to_reg;
    assign bus.write_30 = w_write_30;
    assign bus.ExtOp    = w_ext_op;
    assign bus.AluSrc   = w_alu_src;
    assign bus.AluOp    = w_alu_op;
    assign bus.dmwr     = w_dmwr;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal  = w_illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;
`endif

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

    localparam int K_ADDU = 0;
    localparam int K_SUBU = 1;
    localparam int K_SLT  = 2;
    localparam int K_ORI  = 3;
    localparam int K_LUI  = 4;
    localparam int K_ADDI = 5;
    localparam int K_LW   = 6;
    localparam int K_SW   = 7;
    localparam int K_BEQ  = 8;
    localparam int K_J    = 9;
    localparam int K_JAL  = 10;
    localparam int K_ILL  = 11;

    typedef struct packed {
        logic       illegal;
        logic       pcwr;
        logic [1:0] npc_op;
        logic       irwr;
        logic       gprwr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       write_30;
        logic       ext_op;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       dmwr;
    } ctl_t;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         total;
    int         bad;
    logic [16:0] exp_q[$];

    mc_ctrl_if bus();

    mc_ctrl #(.STATE_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c            = '0;
        c.pcwr       = bus.pcwr;
        c.npc_op     = bus.npc_op;
        c.irwr       = bus.irwr;
        c.gprwr      = bus.gprwr;
        c.reg_dst    = bus.RegDst;
        c.mem_to_reg = bus.MemToReg;
        c.write_30   = bus.write_30;
        c.ext_op     = bus.ExtOp;
        c.alu_src    = bus.AluSrc;
        c.alu_op     = bus.AluOp;
        c.dmwr       = bus.dmwr;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        c.illegal    = bus.illegal;
`endif
        return c;
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_ADDU: return "addu";
            K_SUBU: return "subu";
            K_SLT:  return "slt";
            K_ORI:  return "ori";
            K_LUI:  return "lui";
            K_ADDI: return "addi";
            K_LW:   return "lw";
            K_SW:   return "sw";
            K_BEQ:  return "beq";
            K_J:    return "j";
            K_JAL:  return "jal";
            default: return "ill";
        endcase
    endfunction

    // driver: put the instruction's IR fields on the bus
    task automatic drive_instr(input int k, input logic zb);
        logic [5:0] f;
        int         pick;
        f = 6'($urandom_range(0, 63));
        bus.zero  = zb;
        bus.funct = f;
        case (k)
            K_ADDU: begin bus.op = 6'h00; bus.funct = 6'h21; end
            K_SUBU: begin bus.op = 6'h00; bus.funct = 6'h23; end
            K_SLT:  begin bus.op = 6'h00; bus.funct = 6'h2A; end
            K_ORI:  bus.op = 6'h0D;
            K_LUI:  bus.op = 6'h0F;
            K_ADDI: bus.op = 6'h08;
            K_LW:   bus.op = 6'h23;
            K_SW:   bus.op = 6'h2B;
            K_BEQ:  bus.op = 6'h04;
            K_J:    bus.op = 6'h02;
            K_JAL:  bus.op = 6'h03;
            default: begin
                pick = $urandom_range(0, 2);
                if (pick == 0) bus.op = 6'h3F;
                else if (pick == 1) bus.op = 6'h05;
                else begin bus.op = 6'h00; bus.funct = 6'h20; end
            end
        endcase
    endtask

    // reference model: per-cycle control words of one instruction, from the
    // instruction-level description of the control unit
    task automatic model_instr(input int k, input logic zb);
        ctl_t c;
        c = '0; c.pcwr = 1'b1; c.irwr = 1'b1;
        exp_q.push_back(c);                                   // IF
        c = '0;
        if (k == K_J || k == K_JAL) begin
            c.pcwr = 1'b1; c.npc_op = 2'b10;
            if (k == K_JAL) begin
                c.gprwr = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
            end
            exp_q.push_back(c);
            return;
        end
        exp_q.push_back(c);                                   // DCD
        if (k == K_ILL) return;
        c = '0;                                               // EXE
        case (k)
            K_SUBU: c.alu_op = 3'b001;
            K_SLT:  c.alu_op = 3'b011;
            K_ORI:  begin c.alu_op = 3'b010; c.alu_src = 1'b1; end
            K_LUI:  begin c.alu_op = 3'b100; c.alu_src = 1'b1; end
            K_ADDI, K_LW, K_SW: begin c.alu_src = 1'b1; c.ext_op = 1'b1; end
            K_BEQ:  begin
                c.alu_op = 3'b001; c.ext_op = 1'b1; c.npc_op = 2'b01; c.pcwr = zb;
            end
            default: ;
        endcase
        exp_q.push_back(c);
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            c = '0; c.dmwr = (k == K_SW);
            exp_q.push_back(c);                               // MEM
            if (k == K_SW) return;
        end
        c = '0; c.gprwr = 1'b1;                               // WB
        if (k <= K_SLT) c.reg_dst = 2'b01;
        if (k == K_LW) c.mem_to_reg = 2'b01;
        if (k == K_ADDI) c.write_30 = 1'b1;
        exp_q.push_back(c);
    endtask

    // Runs one instruction through the scoreboard. When abort_at >= 0, reset
    // is pulled low for two edges at that cycle index instead of checking it.
    task automatic run_instr(input int k, input logic zb, input int abort_at);
        ctl_t e;
        int   i;
        drive_instr(k, zb);
        model_instr(k, zb);
        i = 0;
        while (exp_q.size() > 0) begin
            if (i == abort_at) begin
                exp_q.delete();
                rst = 1'b0;
                for (int r = 0; r < 2; r++) begin
                    @(negedge clk);
                    check($sformatf("rst_abort_%0d", r), 32'(observe()), 32'd0);
                    @(posedge clk); #1;
                end
                rst = 1'b1;
                return;
            end
            e = exp_q.pop_front();
            @(negedge clk);
            check($sformatf("%s_c%0d", kname(k), i), 32'(observe()), 32'(e));
            @(posedge clk); #1;
            i++;
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (k == K_ILL) begin
            e = '0; e.illegal = 1'b1;
            for (int t = 0; t < 3; t++) begin
                @(negedge clk);
                check($sformatf("trap_%0d", t), 32'(observe()), 32'(e));
                @(posedge clk); #1;
            end
            rst = 1'b0;
            @(negedge clk);
            check("trap_rst", 32'(observe()), 32'd0);
            @(posedge clk); #1;
            rst = 1'b1;
        end
`endif
    endtask

    int dir_k[10] = '{K_ADDU, K_LW, K_SW, K_BEQ, K_BEQ, K_JAL, K_J, K_ADDI, K_ILL, K_SLT};
    logic dir_z[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.op    = 6'h03;   // jal pending, must stay masked during reset
        bus.funct = 6'h00;
        bus.zero  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(observe()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // addu aborted in WB (cycle index 3), then normal fetch resumes
        run_instr(K_ADDU, 1'b0, 3);

        for (int n = 0; n < 10; n++) run_instr(dir_k[n], dir_z[n], -1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0)
                run_instr(K_ADDU + $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                          $urandom_range(1, 3));
            else
                run_instr($urandom_range(0, 11), 1'($urandom_range(0, 1)), -1);
        end

        // the cycle after the last instruction must be a fetch
        @(negedge clk);
        check("final_if", {31'd0, bus.irwr}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
